// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    // One decoded key event: break/extended prefix flags plus the scan code.
    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } key_event_t;

    // Frame deserialiser states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    // Prefix bytes that are folded into the following key event.
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Bit positions inside the CPU-visible data word.
    localparam int DOUT_VALID = 15;
    localparam int DOUT_OVF   = 14;
    localparam int DOUT_BRK   = 13;
    localparam int DOUT_EXT   = 12;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame deserialiser.
// Produces one-cycle pulses: byte_valid (good frame), frame_err (bad
// parity or stop bit) and timeout (partial frame abandoned).
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       timeout
);

    localparam int FLT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [FLT_W-1:0] FLT_MAX = FLT_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       c_sync_reg;
    logic [1:0]       d_sync_reg;
    logic [FLT_W-1:0] flt_cnt_reg;
    logic             ps2c_f_reg;
    logic             ps2c_f_d_reg;
    logic             strobe_reg;
    logic [TO_W-1:0]  to_cnt_reg;
    logic             to_hit;
    logic             d_bit;

    frame_state_t state_reg, state_next;
    logic [2:0]   bit_cnt_reg, bit_cnt_next;
    logic [7:0]   shift_reg, shift_next;
    logic         par_reg, par_next;

    // Two-flop synchronisers; idle line level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_sync_reg <= 2'b11;
            d_sync_reg <= 2'b11;
        end else begin
            c_sync_reg <= {c_sync_reg[0], ps2c};
            d_sync_reg <= {d_sync_reg[0], ps2d};
        end
    end

    // Glitch filter: the clock only flips after FILTER_LEN differing samples in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flt_cnt_reg <= '0;
            ps2c_f_reg  <= 1'b1;
        end else if (c_sync_reg[1] == ps2c_f_reg) begin
            flt_cnt_reg <= '0;
        end else if (flt_cnt_reg == FLT_MAX) begin
            flt_cnt_reg <= '0;
            ps2c_f_reg  <= c_sync_reg[1];
        end else begin
            flt_cnt_reg <= flt_cnt_reg + 1'b1;
        end
    end

    // Registered falling-edge detector on the filtered clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2c_f_d_reg <= 1'b1;
            strobe_reg   <= 1'b0;
        end else begin
            ps2c_f_d_reg <= ps2c_f_reg;
            strobe_reg   <= ps2c_f_d_reg & ~ps2c_f_reg;
        end
    end

    // Saturating idle counter, cleared by every bit strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_reg <= '0;
        end else if (strobe_reg) begin
            to_cnt_reg <= '0;
        end else if (to_cnt_reg != TO_MAX) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
        end
    end

    assign to_hit  = (to_cnt_reg == TO_MAX);
    assign d_bit   = d_sync_reg[1];
    assign rx_byte = shift_reg;

    // Frame FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            par_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            par_reg     <= par_next;
        end
    end

    // Frame FSM next-state and pulse outputs; a strobe wins over a timeout.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        par_next     = par_reg;
        byte_valid   = 1'b0;
        frame_err    = 1'b0;
        timeout      = 1'b0;
        if (strobe_reg) begin
            case (state_reg)
                ST_IDLE: begin
                    if (!d_bit) begin
                        state_next   = ST_DATA;
                        bit_cnt_next = '0;
                    end
                end
                ST_DATA: begin
                    shift_next   = {d_bit, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_next   = d_bit;
                    state_next = ST_STOP;
                end
                ST_STOP: begin
                    if (d_bit && (^{par_reg, shift_reg})) begin
                        byte_valid = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (state_reg != ST_IDLE && to_hit) begin
            state_next = ST_IDLE;
            timeout    = 1'b1;
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frame deserialiser, E0/F0 prefix folding and
// a small key-event FIFO popped by the CPU with a one-cycle ack.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2c,
    input  logic        ps2d,
    input  logic        ack,
    output logic [15:0] dout,
    output logic        irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       frame_err;
    logic       timeout;

    logic       ext_reg;
    logic       brk_reg;
    logic       ovf_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    key_event_t fifo_mem [FIFO_DEPTH];

    logic       is_prefix;
    logic       push_req;
    logic       push_ok;
    logic       pop;
    logic       empty;
    logic       full;
    key_event_t push_event;
    key_event_t head;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2c       (ps2c),
        .ps2d       (ps2d),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err),
        .timeout    (timeout)
    );

    assign is_prefix  = (rx_byte == PS2_EXT) || (rx_byte == PS2_BRK);
    assign push_req   = byte_valid && !is_prefix;
    assign empty      = (count_reg == '0);
    assign full       = (count_reg == CNT_FULL);
    assign pop        = ack && !empty;
    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign push_ok    = push_req && (!full || pop);
    assign push_event = '{brk: brk_reg, ext: ext_reg, code: rx_byte};
    assign head       = fifo_mem[rd_ptr_reg];

    // Prefix flags accumulate until a real code is pushed or the frame is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
        end else if (frame_err || timeout) begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
        end else if (byte_valid) begin
            if (rx_byte == PS2_EXT) begin
                ext_reg <= 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk_reg <= 1'b1;
            end else begin
                ext_reg <= 1'b0;
                brk_reg <= 1'b0;
            end
        end
    end

    // Event storage; contents need no reset because empty entries are never shown.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= push_event;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (pop) begin
                ovf_reg <= 1'b0;
            end else if (push_req && full) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    // CPU data word built from the FIFO head; all zero when empty.
    always_comb begin
        dout = '0;
        if (!empty) begin
            dout[DOUT_VALID] = 1'b1;
            dout[DOUT_OVF]   = ovf_reg;
            dout[DOUT_BRK]   = head.brk;
            dout[DOUT_EXT]   = head.ext;
            dout[7:0]        = head.code;
        end
    end

    assign irq = !empty;

endmodule
